// File: rtl/riscv_defines.sv
// Shared widths, encodings and controller state type for the RV32I core.
package riscv_defines;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int RISCV_ADDR_WIDTH = 32;

    // addi x0, x0, 0: what the decoder sees before the first real fetch.
    localparam logic [RISCV_WORD_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        EXECUTE    = 3'd3,
        TRAP       = 3'd4,
        HALTED     = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the single-issue RV32I core: fetch handshake,
// instruction/PC latch for the decoder, one-cycle register-file write gate,
// PC advance, illegal-instruction trap redirect and halt handling.
module core_ctrl
    import riscv_defines::*;
#(
    parameter logic [RISCV_ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [RISCV_ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
    output logic [RISCV_WORD_WIDTH-1:0] instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_q_o,
    input  logic                        dec_rf_we_i,
    input  logic                        dec_illegal_i,
    output logic                        rf_we_o,
    input  logic                        halt_i,
    output logic                        halted_o,
    output logic                        trap_o,
    output logic [RISCV_ADDR_WIDTH-1:0] trap_pc_o,
    output logic [31:0]                 instret_o
);

    // The PC is kept as a word index so its two low bits are zero by construction.
    localparam int PCW = RISCV_ADDR_WIDTH - 2;
    localparam logic [PCW-1:0] RESET_PC_W    = RESET_PC[RISCV_ADDR_WIDTH-1:2];
    localparam logic [PCW-1:0] TRAP_VECTOR_W = TRAP_VECTOR[RISCV_ADDR_WIDTH-1:2];

    ctrl_state_t                 r_state;
    logic [PCW-1:0]              r_pc;
    logic [RISCV_WORD_WIDTH-1:0] r_instr;
    logic [RISCV_ADDR_WIDTH-1:0] r_instr_addr_q;
    logic [31:0]                 r_instret;

    ctrl_state_t                 w_state_next;
    logic [PCW-1:0]              w_pc_next;
    logic [RISCV_WORD_WIDTH-1:0] w_instr_next;
    logic [RISCV_ADDR_WIDTH-1:0] w_instr_addr_q_next;
    logic [31:0]                 w_instret_next;
    logic                        w_rf_we;
    logic [RISCV_ADDR_WIDTH-1:0] w_pc_byte;

    assign w_pc_byte = {r_pc, 2'b00};

    // State and datapath registers; reset returns everything to the boot image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC_W;
            r_instr        <= INSTR_NOP;
            r_instr_addr_q <= {RESET_PC_W, 2'b00};
            r_instret      <= 32'd0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_instr        <= w_instr_next;
            r_instr_addr_q <= w_instr_addr_q_next;
            r_instret      <= w_instret_next;
        end
    end

    // Next-state, datapath update and the input-dependent write gate.
    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_instr_next        = r_instr;
        w_instr_addr_q_next = r_instr_addr_q;
        w_instret_next      = r_instret;
        w_rf_we             = 1'b0;

        case (r_state)
            BOOT: begin
                w_state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                // Request and address stay put until the memory accepts.
                if (instr_gnt_i) begin
                    w_state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (instr_rvalid_i) begin
                    w_instr_next        = instr_rdata_i;
                    w_instr_addr_q_next = w_pc_byte;
                    w_state_next        = EXECUTE;
                end
            end
            EXECUTE: begin
                if (dec_illegal_i) begin
                    // Nothing retires; the trap cycle redirects the PC.
                    w_state_next = TRAP;
                end else begin
                    w_rf_we        = dec_rf_we_i;
                    w_pc_next      = r_pc + 1'b1;
                    w_instret_next = r_instret + 32'd1;
                    w_state_next   = halt_i ? HALTED : FETCH_REQ;
                end
            end
            TRAP: begin
                w_pc_next    = TRAP_VECTOR_W;
                w_state_next = halt_i ? HALTED : FETCH_REQ;
            end
            HALTED: begin
                if (!halt_i) begin
                    w_state_next = FETCH_REQ;
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    assign instr_req_o    = (r_state == FETCH_REQ);
    assign instr_addr_o   = w_pc_byte;
    assign instr_o        = r_instr;
    assign instr_addr_q_o = r_instr_addr_q;
    assign rf_we_o        = w_rf_we;
    assign halted_o       = (r_state == HALTED);
    assign trap_o         = (r_state == TRAP);
    assign trap_pc_o      = (r_state == TRAP) ? r_instr_addr_q : '0;
    assign instret_o      = r_instret;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: per-cycle comparison against a
// transaction-level model, directed scenarios, then randomized traffic.
module tb_core_ctrl;
    import riscv_defines::*;

    localparam logic [31:0] TVEC = 32'h0000_0100;
    localparam int P_BOOT = 0, P_REQ = 1, P_WAIT = 2, P_EXEC = 3, P_TRAP = 4, P_HALT = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, instr_req_o, instr_gnt_i, instr_rvalid_i;
    logic [31:0] instr_addr_o, instr_rdata_i, instr_o, instr_addr_q_o, trap_pc_o, instret_o;
    logic        dec_rf_we_i, dec_illegal_i, rf_we_o, halt_i, halted_o, trap_o;

    core_ctrl #(.RESET_PC(32'h0), .TRAP_VECTOR(TVEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_o(instr_o),
        .instr_addr_q_o(instr_addr_q_o), .dec_rf_we_i(dec_rf_we_i),
        .dec_illegal_i(dec_illegal_i), .rf_we_o(rf_we_o), .halt_i(halt_i),
        .halted_o(halted_o), .trap_o(trap_o), .trap_pc_o(trap_pc_o),
        .instret_o(instret_o)
    );

    // Second instance to exercise PC wrap from the top of the address space.
    logic        rst2_n, req2, gnt2, rvalid2, we2, ill2, rfwe2, halt2, halted2, trap2;
    logic [31:0] addr2, rdata2, instr2, iaddrq2, trappc2, instret2;

    core_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TRAP_VECTOR(TVEC)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .instr_req_o(req2), .instr_addr_o(addr2),
        .instr_gnt_i(gnt2), .instr_rvalid_i(rvalid2),
        .instr_rdata_i(rdata2), .instr_o(instr2),
        .instr_addr_q_o(iaddrq2), .dec_rf_we_i(we2),
        .dec_illegal_i(ill2), .rf_we_o(rfwe2), .halt_i(halt2),
        .halted_o(halted2), .trap_o(trap2), .trap_pc_o(trappc2),
        .instret_o(instret2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: where the core is in its instruction, plus architectural state.
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_iaddr, m_instret;

    function automatic void model_reset();
        m_phase   = P_BOOT;
        m_pc      = 32'h0;
        m_instr   = 32'h0000_0013;
        m_iaddr   = 32'h0;
        m_instret = 32'h0;
    endfunction

    function automatic void model_step();
        case (m_phase)
            P_BOOT: m_phase = P_REQ;
            P_REQ:  if (instr_gnt_i) m_phase = P_WAIT;
            P_WAIT: if (instr_rvalid_i) begin
                m_instr = instr_rdata_i;
                m_iaddr = m_pc;
                m_phase = P_EXEC;
            end
            P_EXEC: if (dec_illegal_i) m_phase = P_TRAP;
                    else begin
                        m_pc      = m_pc + 32'd4;
                        m_instret = m_instret + 32'd1;
                        m_phase   = halt_i ? P_HALT : P_REQ;
                    end
            P_TRAP: begin
                m_pc    = TVEC;
                m_phase = halt_i ? P_HALT : P_REQ;
            end
            default: if (!halt_i) m_phase = P_REQ;
        endcase
    endfunction

    // Instruction memory contents seen by the responder.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h8 || a[6:2] == 5'd17) return 32'hFFFF_FFFF;
        w = a * 32'h9E37_79B1;
        return {w[31:2], 2'b11};
    endfunction

    // Responder / stimulus knobs
    int          gd, rd, gcnt, rcnt, halt_mode, halted_cnt;
    bit          pend, spur_en, rnd_mode, we_force;
    logic [31:0] paddr;

    task automatic compare();
        logic exp_we, exp_trap;
        exp_we   = (m_phase == P_EXEC) && !dec_illegal_i && dec_rf_we_i;
        exp_trap = (m_phase == P_TRAP);
        chk("instr_req_o", 32'(instr_req_o), 32'(m_phase == P_REQ));
        chk("instr_addr_o", instr_addr_o, m_pc);
        chk("instr_o", instr_o, m_instr);
        chk("instr_addr_q_o", instr_addr_q_o, m_iaddr);
        chk("rf_we_o", 32'(rf_we_o), 32'(exp_we));
        chk("trap_o", 32'(trap_o), 32'(exp_trap));
        chk("trap_pc_o", trap_pc_o, exp_trap ? m_iaddr : 32'h0);
        chk("halted_o", 32'(halted_o), 32'(m_phase == P_HALT));
        chk("instret_o", instret_o, m_instret);
    endtask

    // Drive one cycle's inputs at the falling edge, then check the outputs.
    task automatic drive(input bit rst);
        @(negedge clk);
        if (rst) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end
        #1;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = $urandom;
        if (pend) begin
            rcnt--;
            if (rcnt <= 0) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(paddr);
                pend = 1'b0;
            end
        end else if (spur_en && $urandom_range(7) == 0) begin
            instr_rvalid_i = 1'b1;
        end
        instr_gnt_i = 1'b0;
        if (instr_req_o) begin
            if (gcnt >= gd) begin
                instr_gnt_i = 1'b1;
                gcnt  = 0;
                pend  = 1'b1;
                rcnt  = rd;
                paddr = instr_addr_o;
                if (rnd_mode) begin
                    gd = $urandom_range(3);
                    rd = $urandom_range(3, 1);
                end
            end else begin
                gcnt++;
            end
        end else begin
            gcnt = 0;
        end
        halt_i = 1'b0;
        if (halt_mode == 1) begin
            halt_i = (m_phase == P_HALT) ? 1'($urandom_range(1)) : ($urandom_range(9) == 0);
        end else if (halt_mode == 2) begin
            if (m_phase == P_EXEC) halt_i = 1'b1;
            else if (m_phase == P_HALT) begin
                halted_cnt++;
                halt_i = (halted_cnt <= 5);
            end
        end
        dec_rf_we_i   = we_force ? 1'b1 : 1'($urandom_range(1));
        dec_illegal_i = (instr_o == 32'hFFFF_FFFF) || (rnd_mode && $urandom_range(15) == 0);
        #1;
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_step();
    endtask

    int  start, we_cnt, req_cnt, hcnt, lat;
    bit  done, seen, saw_trap, stale_seen;

    initial begin
        rst_n = 1'b1; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
        dec_rf_we_i = 0; dec_illegal_i = 0; halt_i = 0;
        rst2_n = 1'b1; gnt2 = 0; rvalid2 = 0; rdata2 = 0; we2 = 0; ill2 = 0; halt2 = 0;
        gd = 0; rd = 1; gcnt = 0; rcnt = 0; pend = 0; spur_en = 0; rnd_mode = 0;
        we_force = 1; halt_mode = 0; halted_cnt = 0; paddr = 0;
        model_reset();

        // Reset state
        drive(1);
        chk("reset_instr_nop", instr_o, 32'h0000_0013);
        chk("reset_req", 32'(instr_req_o), 32'd0);
        advance();
        drive(1);
        advance();

        // 1: zero-wait fetch of addi x1,x0,5 at RESET_PC
        done = 0; seen = 0; we_cnt = 0; start = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(0);
            if (instr_req_o && !seen) begin
                seen = 1; start = i;
                chk("t1_first_addr", instr_addr_o, 32'h0);
            end
            if (rf_we_o) begin
                we_cnt++;
                chk("t1_exec_instr", instr_o, 32'h0050_0093);
            end
            advance();
            if (m_phase == P_REQ && m_instret == 1) begin
                done = 1; lat = i + 1 - start;
            end
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_we_cycles", we_cnt, 1);
        chk("t1_latency", lat, 3);

        // 2: slow grant and slow data at PC 4
        gd = 3; rd = 2; we_force = 0; done = 0; req_cnt = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            drive(0);
            if (i == 0) begin
                chk("t1_next_addr", instr_addr_o, 32'h4);
                chk("t1_instret", instret_o, 32'd1);
            end
            if (instr_req_o) req_cnt++;
            if (instr_req_o) chk("t2_addr_stable", instr_addr_o, 32'h4);
            advance();
            if (m_phase == P_REQ && m_instret == 2) done = 1;
            if (done) begin gd = 0; rd = 1; end
        end
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_req_cycles", req_cnt, 4);

        // 3: illegal word at PC 8 traps
        we_force = 1; done = 0; saw_trap = 0; we_cnt = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(0);
            if (i == 0) chk("t3_fetch_addr", instr_addr_o, 32'h8);
            if (rf_we_o) we_cnt++;
            if (trap_o) begin
                saw_trap = 1;
                chk("t3_trap_pc", trap_pc_o, 32'h8);
            end
            advance();
            if (saw_trap && m_phase == P_REQ) done = 1;
        end
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_no_rf_we", we_cnt, 0);

        // 4: halt during EXECUTE, release after 5 cycles
        halt_mode = 2; halted_cnt = 0; done = 0; hcnt = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            drive(0);
            if (i == 0) begin
                chk("t3_redirect_addr", instr_addr_o, 32'h100);
                chk("t3_instret_kept", instret_o, 32'd2);
            end
            if (halted_o) hcnt++;
            advance();
            if (halted_cnt > 5 && m_phase == P_REQ) done = 1;
        end
        halt_mode = 0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_halted_cycles", hcnt, 6);

        // 6: reset during FETCH_WAIT, stale rvalid afterwards
        gd = 0; rd = 4; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            drive(0);
            if (i == 0) chk("t4_resume_addr", instr_addr_o, 32'h104);
            advance();
            if (m_phase == P_WAIT) done = 1;
        end
        chk("t6_reached_wait", 32'(done), 32'd1);
        drive(1); advance();
        drive(1); advance();
        stale_seen = 0; seen = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0);
            if (instr_rvalid_i) stale_seen = 1;
            if (instr_req_o && !seen) begin
                seen = 1;
                chk("t6_refetch_addr", instr_addr_o, 32'h0);
            end
            chk("t6_instr_nop", instr_o, 32'h0000_0013);
            advance();
        end
        chk("t6_stale_rvalid_sent", 32'(stale_seen), 32'd1);

        // Randomized traffic
        rnd_mode = 1; spur_en = 1; halt_mode = 1; we_force = 0;
        gd = 1; rd = 2;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(399) == 0);
            advance();
        end

        // 5: PC wrap from 32'hFFFF_FFFC
        @(negedge clk); rst2_n = 1'b0;
        @(negedge clk); rst2_n = 1'b1; #1;
        chk("t5_boot_req", 32'(req2), 32'd0);
        chk("t5_boot_instr", instr2, 32'h0000_0013);
        @(negedge clk); #1;
        chk("t5_req", 32'(req2), 32'd1);
        chk("t5_addr", addr2, 32'hFFFF_FFFC);
        gnt2 = 1'b1;
        @(negedge clk); gnt2 = 1'b0; rvalid2 = 1'b1; rdata2 = 32'h0050_0093; #1;
        chk("t5_wait_req", 32'(req2), 32'd0);
        @(negedge clk); rvalid2 = 1'b0; we2 = 1'b1; #1;
        chk("t5_rf_we", 32'(rfwe2), 32'd1);
        chk("t5_instr", instr2, 32'h0050_0093);
        chk("t5_instr_addr_q", iaddrq2, 32'hFFFF_FFFC);
        @(negedge clk); we2 = 1'b0; #1;
        chk("t5_wrap_req", 32'(req2), 32'd1);
        chk("t5_wrap_addr", addr2, 32'h0);
        chk("t5_instret", instret2, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
